rotate_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit right-rotate datapath among four requesters. Each requester presents a data byte and a rotate amount over a valid/ready handshake. The scheduler grants one request per cycle, rotates the byte, and holds the result in a one-entry output register, tagged with the requester ID. It sits between the rotate clients and the downstream consumer, and it is the only path into the rotator.

---
 rtl/rotate_pkg.sv | 22 ++
 rtl/rotate_scheduler_if.sv | 25 ++
 rtl/rr_arb4.sv | 31 +++
 rtl/rotate_scheduler.sv | 93 +++++++++
 tb/tb_rotate_scheduler.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rotate_pkg.sv
// Shared constants, output-register state type and the reference rotate-right
// function for the rotate scheduler.
package rotate_pkg;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int AMTW = 3;
  localparam int IDW  = 2;

  typedef enum logic {EMPTY, FULL} state_e;

  // Bit k of the result takes bit (k+amt) mod W of the input.
  function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input logic [AMTW-1:0] amt);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      r[k] = d[(k + int'(amt)) % W];
    end
    return r;
  endfunction

endpackage

// File: rtl/rotate_scheduler_if.sv
// Requester/consumer bundle of the rotate scheduler; slave is the scheduler side.
interface rotate_scheduler_if;
  import rotate_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ*AMTW-1:0] req_amt;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_ready;
  logic [15:0]          xfer_count;

  modport slave (
    input  req_valid, req_data, req_amt, out_ready,
    output req_ready, out_valid, out_data, out_id, xfer_count
  );

  modport master (
    output req_valid, req_data, req_amt, out_ready,
    input  req_ready, out_valid, out_data, out_id, xfer_count
  );

endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: search starts just after last_id,
// so the most recently served requester has the lowest priority.
module rr_arb4
  import rotate_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last_id,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  logic [IDW-1:0] idx;

  // Walk from the farthest offset down to the nearest so the nearest valid requester wins.
  always_comb begin
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_id + k[IDW-1:0];
      if (valid[idx]) begin
        grant_id = idx;
        any      = 1'b1;
      end
    end
  end

  assign grant_onehot = any ? (NREQ'(1) << grant_id) : '0;

endmodule

// File: rtl/rotate_scheduler.sv
// Round-robin scheduler sharing one 8-bit rotate-right datapath among four
// requesters, with a one-entry tagged output register.
module rotate_scheduler
  import rotate_pkg::*;
(
  input logic          clk,
  input logic          rst,
  rotate_scheduler_if.slave bus
);

  state_e          state_q;
  logic [W-1:0]    outData_q;
  logic [W-1:0]    rotData_d;
  logic [IDW-1:0]  outId_q;
  logic [IDW-1:0]  lastId_q;
  logic [15:0]     xferCount_q;
  logic [NREQ-1:0] grantOnehot;
  logic [IDW-1:0]  grantId;
  logic            anyValid;
  logic            canLoad;
  logic            accept;
  logic            drain;
  logic [W-1:0]    selData;
  logic [AMTW-1:0] selAmt;

  rr_arb4 uArb (
    .valid        (bus.req_valid),
    .last_id      (lastId_q),
    .grant_onehot (grantOnehot),
    .grant_id     (grantId),
    .any          (anyValid)
  );

  assign drain         = (state_q == FULL) && bus.out_ready;
  assign canLoad       = (state_q == EMPTY) || bus.out_ready;
  assign accept        = canLoad && anyValid;
  assign bus.req_ready = accept ? grantOnehot : '0;

  always_comb begin
    selData = '0;
    selAmt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantId == i[IDW-1:0]) begin
        selData = bus.req_data[i*W +: W];
        selAmt  = bus.req_amt[i*AMTW +: AMTW];
      end
    end
  end

  always_comb begin
    rotData_d = selData;
    case (selAmt)
      3'd0: rotData_d = selData;
      3'd1: rotData_d = {selData[0],   selData[7:1]};
      3'd2: rotData_d = {selData[1:0], selData[7:2]};
      3'd3: rotData_d = {selData[2:0], selData[7:3]};
      3'd4: rotData_d = {selData[3:0], selData[7:4]};
      3'd5: rotData_d = {selData[4:0], selData[7:5]};
      3'd6: rotData_d = {selData[5:0], selData[7:6]};
      3'd7: rotData_d = {selData[6:0], selData[7]};
      default: rotData_d = selData;
    endcase
  end

  // A drain without a new winner empties the register; contents are left as they were.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      outData_q   <= '0;
      outId_q     <= '0;
      lastId_q    <= IDW'(NREQ - 1);
      xferCount_q <= '0;
    end else begin
      if (drain) begin
        xferCount_q <= xferCount_q + 16'd1;
      end
      if (accept) begin
        outData_q <= rotData_d;
        outId_q   <= grantId;
        lastId_q  <= grantId;
        state_q   <= FULL;
      end else if (drain) begin
        state_q <= EMPTY;
      end
    end
  end

  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_data   = outData_q;
  assign bus.out_id     = outId_q;
  assign bus.xfer_count = xferCount_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Directed table-driven bench for rotate_scheduler plus hand-written sequences
// for fairness, backpressure, asynchronous reset and counter wrap.
module tb_rotate_scheduler;
  import rotate_pkg::*;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [11:0] amt;
    logic        outReady;
    logic [3:0]  expReady;
    logic        expValid;
    logic [7:0]  expData;
    logic        chkData;
    logic [1:0]  expId;
    logic [15:0] expCount;
  } vec_t;

  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;
  int   stallCount;
  vec_t vecs[10];
  logic [7:0] fairData[4];

  rotate_scheduler_if bus();

  rotate_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [11:0] a, input logic r);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_amt   = a;
    bus.out_ready = r;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    @(negedge clk);
    drive(v.valid, v.data, v.amt, v.outReady);
    #1;
    checkOutput($sformatf("vec%0d req_ready", n), 16'(bus.req_ready), 16'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d out_valid", n), 16'(bus.out_valid), 16'(v.expValid));
    checkOutput($sformatf("vec%0d xfer_count", n), bus.xfer_count, v.expCount);
    if (v.chkData) begin
      checkOutput($sformatf("vec%0d out_data", n), 16'(bus.out_data), 16'(v.expData));
      checkOutput($sformatf("vec%0d out_id", n), 16'(bus.out_id), 16'(v.expId));
    end
  endtask

  // One cycle with fixed inputs: check req_ready before the edge and outputs after it.
  task automatic stepCheck(input string name, input logic [3:0] expReady, input logic expValid,
                           input logic [7:0] expData, input logic [1:0] expId, input logic [15:0] expCount);
    #1;
    checkOutput({name, " req_ready"}, 16'(bus.req_ready), 16'(expReady));
    @(posedge clk);
    #1;
    checkOutput({name, " out_valid"}, 16'(bus.out_valid), 16'(expValid));
    checkOutput({name, " xfer_count"}, bus.xfer_count, expCount);
    if (expValid) begin
      checkOutput({name, " out_data"}, 16'(bus.out_data), 16'(expData));
      checkOutput({name, " out_id"}, 16'(bus.out_id), 16'(expId));
    end
    @(negedge clk);
  endtask

  initial begin
    vecCount   = 0;
    missCount  = 0;
    stallCount = 0;
    //              valid    data          amt     rdy   expRdy   vld   data   chk  id    count
    vecs[0] = '{4'b0001, 32'h0000_00B4, 12'h001, 1'b0, 4'b0001, 1'b1, 8'h5A, 1'b1, 2'd0, 16'd0};
    vecs[1] = '{4'b0000, 32'h0000_0000, 12'h000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd1};
    vecs[2] = '{4'b0100, 32'h0081_0000, 12'h0C0, 1'b0, 4'b0100, 1'b1, 8'h30, 1'b1, 2'd2, 16'd1};
    vecs[3] = '{4'b0100, 32'h0081_0000, 12'h000, 1'b1, 4'b0100, 1'b1, 8'h81, 1'b1, 2'd2, 16'd2};
    vecs[4] = '{4'b0100, 32'h0081_0000, 12'h1C0, 1'b1, 4'b0100, 1'b1, 8'h03, 1'b1, 2'd2, 16'd3};
    vecs[5] = '{4'b0000, 32'h0000_0000, 12'h000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd4};
    vecs[6] = '{4'b1010, 32'hF000_0F00, 12'h420, 1'b0, 4'b1000, 1'b1, 8'h3C, 1'b1, 2'd3, 16'd4};
    vecs[7] = '{4'b1010, 32'hF000_0F00, 12'h420, 1'b0, 4'b0000, 1'b1, 8'h3C, 1'b1, 2'd3, 16'd4};
    vecs[8] = '{4'b1010, 32'hF000_0F00, 12'h420, 1'b1, 4'b0010, 1'b1, 8'hF0, 1'b1, 2'd1, 16'd5};
    vecs[9] = '{4'b0000, 32'h0000_0000, 12'h000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd6};
    fairData[0] = 8'h88;
    fairData[1] = 8'h11;
    fairData[2] = 8'h22;
    fairData[3] = 8'h44;

    rst = 1'b1;
    drive(4'b0000, 32'h0, 12'h0, 1'b0);
    #12;
    checkOutput("reset out_valid", 16'(bus.out_valid), 16'd0);
    checkOutput("reset out_data", 16'(bus.out_data), 16'h00);
    checkOutput("reset out_id", 16'(bus.out_id), 16'd0);
    checkOutput("reset xfer_count", bus.xfer_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Fairness from reset: all four valid, consumer always ready.
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(4'b1111, 32'h8844_2211, 12'h249, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fair%0d model", i), 16'(rotr(bus.req_data[(i%4)*8 +: 8], 3'd1)), 16'(fairData[i%4]));
      stepCheck($sformatf("fair%0d", i), 4'(1 << (i % 4)), 1'b1, fairData[i%4], 2'(i % 4), 16'(i));
    end

    // Backpressure: register holds requester 3's result while 1 and 3 wait.
    drive(4'b1010, 32'h8844_2211, 12'h249, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepCheck($sformatf("stall%0d", i), 4'b0000, 1'b1, 8'h44, 2'd3, 16'd7);
    end
    bus.out_ready = 1'b1;
    stepCheck("resume1", 4'b0010, 1'b1, 8'h11, 2'd1, 16'd8);
    stepCheck("resume3", 4'b1000, 1'b1, 8'h44, 2'd3, 16'd9);
    bus.req_valid = 4'b0000;
    stepCheck("resumeDrain", 4'b0000, 1'b0, 8'h00, 2'd0, 16'd10);

    // Asynchronous reset in the middle of the high phase while FULL.
    drive(4'b0001, 32'h8844_2211, 12'h249, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("preRst out_valid", 16'(bus.out_valid), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRst out_valid", 16'(bus.out_valid), 16'd0);
    checkOutput("asyncRst out_data", 16'(bus.out_data), 16'h00);
    checkOutput("asyncRst xfer_count", bus.xfer_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 32'h8844_2211, 12'h249, 1'b0);
    stepCheck("postRst", 4'b0001, 1'b1, 8'h88, 2'd0, 16'd0);

    // Counter wrap: register is FULL, so every cycle is a handshake.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      #1;
      if (bus.req_ready == 4'b0000) stallCount++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("wrap count 0xFFFF", bus.xfer_count, 16'hFFFF);
    @(posedge clk);
    #1;
    checkOutput("wrap count 0x0000", bus.xfer_count, 16'h0000);
    checkOutput("wrap out_valid", 16'(bus.out_valid), 16'd1);
    checkOutput("wrap stall cycles", 16'(stallCount), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
